// File: rtl/ysyx_23060221_wbu.sv
// Write-back / commit stage: owns the GPR file, machine CSRs and architectural PC,
// commits one instruction per handshake and offers the next PC to fetch.
module ysyx_23060221_wbu #(
    parameter logic [31:0] RESET_PC    = 32'h3000_0000,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXU_valid,
    output logic        WBU_ready,
    output logic        WBU_valid,
    input  logic        IFU_ready,
    input  logic [31:0] exu_pc,
    input  logic [31:0] exu_imm,
    input  logic [31:0] exu_src1,
    input  logic        PCAsrc,
    input  logic        PCBsrc,
    input  logic [31:0] wd,
    input  logic [4:0]  rd,
    input  logic        regwr,
    input  logic        csrw,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csrwdata,
    input  logic        ecall,
    input  logic        mret,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csrrdata,
    output logic [31:0] pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        commit_s;
    logic [31:0] base_s;
    logic [31:0] offset_s;
    logic [31:0] sum_s;
    logic [31:0] npc_s;
    logic [31:0] pc_r;
    logic [31:0] mstatus_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [31:0] gpr_r [0:31];

    assign commit_s = EXU_valid & WBU_ready;
    assign pc       = pc_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (EXU_valid) begin
                    state_nxt_s = ST_OFFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (IFU_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OFFER;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        WBU_ready = 1'b0;
        WBU_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                WBU_ready = 1'b1;
                WBU_valid = 1'b0;
            end
            ST_OFFER: begin
                WBU_ready = 1'b0;
                WBU_valid = 1'b1;
            end
            default: begin
                WBU_ready = 1'b0;
                WBU_valid = 1'b0;
            end
        endcase
    end

    // Next-PC selection: trap entry beats trap return beats normal flow
    always_comb begin
        base_s   = PCBsrc ? exu_src1 : exu_pc;
        offset_s = PCAsrc ? exu_imm : 32'd4;
        sum_s    = base_s + offset_s;
        if (PCBsrc) begin
            sum_s[0] = 1'b0;
        end else begin
            sum_s[0] = sum_s[0];
        end
        if (ecall) begin
            npc_s = {mtvec_r[31:2], 2'b00};
        end else if (mret) begin
            npc_s = mepc_r;
        end else begin
            npc_s = sum_s;
        end
    end

    // Architectural PC update at commit
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (commit_s) begin
            pc_r <= npc_s;
        end
    end

    // GPR write port; x1-x31 deliberately carry no reset
    always_ff @(posedge clk) begin
        if (!rst && commit_s && regwr && (rd != 5'd0)) begin
            gpr_r[rd] <= wd;
        end
    end

    // CSR updates; ecall bookkeeping is applied last so it overrides a csrw to mepc/mcause
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_r <= MSTATUS_RST;
            mtvec_r   <= 32'd0;
            mepc_r    <= 32'd0;
            mcause_r  <= 32'd0;
        end else if (commit_s) begin
            if (csrw) begin
                case (csr_addr)
                    CSR_MSTATUS: mstatus_r <= csrwdata;
                    CSR_MTVEC:   mtvec_r   <= csrwdata;
                    CSR_MEPC:    mepc_r    <= csrwdata;
                    CSR_MCAUSE:  mcause_r  <= csrwdata;
                    default:     mstatus_r <= mstatus_r;
                endcase
            end
            if (ecall) begin
                mepc_r   <= exu_pc;
                mcause_r <= 32'd11;
            end
        end
    end

    // Combinational GPR read ports, x0 hard-wired to zero
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = 32'd0;
        end else begin
            rdata1 = gpr_r[raddr1];
        end
        if (raddr2 == 5'd0) begin
            rdata2 = 32'd0;
        end else begin
            rdata2 = gpr_r[raddr2];
        end
    end

    // Combinational CSR read port, unimplemented addresses read zero
    always_comb begin
        case (csr_raddr)
            CSR_MSTATUS: csrrdata = mstatus_r;
            CSR_MTVEC:   csrrdata = mtvec_r;
            CSR_MEPC:    csrrdata = mepc_r;
            CSR_MCAUSE:  csrrdata = mcause_r;
            default:     csrrdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060221_wbu.sv
// Bench for ysyx_23060221_wbu: table of single-instruction commits plus
// hand-written back-pressure and reset sequences.
module tb_ysyx_23060221_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXU_valid;
    logic        WBU_ready;
    logic        WBU_valid;
    logic        IFU_ready;
    logic [31:0] exu_pc;
    logic [31:0] exu_imm;
    logic [31:0] exu_src1;
    logic        PCAsrc;
    logic        PCBsrc;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        regwr;
    logic        csrw;
    logic [11:0] csr_addr;
    logic [31:0] csrwdata;
    logic        ecall;
    logic        mret;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [11:0] csr_raddr;
    logic [31:0] csrrdata;
    logic [31:0] pc;

    int tests_run = 0;
    int tests_failed = 0;

    ysyx_23060221_wbu dut (
        .clk(clk), .rst(rst), .EXU_valid(EXU_valid), .WBU_ready(WBU_ready),
        .WBU_valid(WBU_valid), .IFU_ready(IFU_ready), .exu_pc(exu_pc),
        .exu_imm(exu_imm), .exu_src1(exu_src1), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc),
        .wd(wd), .rd(rd), .regwr(regwr), .csrw(csrw), .csr_addr(csr_addr),
        .csrwdata(csrwdata), .ecall(ecall), .mret(mret), .raddr1(raddr1),
        .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2), .csr_raddr(csr_raddr),
        .csrrdata(csrrdata), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] src1;
        logic        pca;
        logic        pcb;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        regwr;
        logic        csrw;
        logic [11:0] csr_addr;
        logic [31:0] csrwdata;
        logic        ecall;
        logic        mret;
        logic [4:0]  chk_raddr;
        logic [31:0] exp_rdata;
        logic [11:0] chk_csr;
        logic [31:0] exp_csr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
        end
    endtask

    task automatic clear_inputs();
        EXU_valid = 1'b0; exu_pc = 32'd0; exu_imm = 32'd0; exu_src1 = 32'd0;
        PCAsrc = 1'b0; PCBsrc = 1'b0; wd = 32'd0; rd = 5'd0; regwr = 1'b0;
        csrw = 1'b0; csr_addr = 12'd0; csrwdata = 32'd0; ecall = 1'b0; mret = 1'b0;
    endtask

    task automatic drive_plain(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
        clear_inputs();
        EXU_valid = 1'b1; exu_pc = p; rd = r; wd = d; regwr = 1'b1;
    endtask

    initial begin
        //          pc            imm           src1          A     B     wd            rd     wr    csrw  caddr    cdata         ecall mret  raddr  exp_rdata     ccsr     exp_csr       exp_pc
        vecs[0]  = {32'h3000_0000, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEAD_BEEF, 5'd5,  1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 12'h300, 32'h0000_1800, 32'h3000_0004};
        vecs[1]  = {32'h3000_0004, 32'h0,        32'h0,        1'b0, 1'b0, 32'h5,         5'd0,  1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0,         12'h305, 32'h0,         32'h3000_0008};
        vecs[2]  = {32'h3000_0008, 32'h4,        32'h8000_0003, 1'b1, 1'b1, 32'h3000_000C, 5'd1,  1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 5'd1,  32'h3000_000C, 12'h341, 32'h0,         32'h8000_0006};
        vecs[3]  = {32'h0000_0100, 32'hFFFF_FFF0, 32'h0,        1'b1, 1'b0, 32'h1111_1111, 5'd5,  1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 12'h342, 32'h0,         32'h0000_00F0};
        vecs[4]  = {32'h0000_00F0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 12'h305, 32'h8000_0101, 1'b0, 1'b0, 5'd1,  32'h3000_000C, 12'h305, 32'h8000_0101, 32'h0000_00F4};
        vecs[5]  = {32'h8000_0040, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 12'h341, 32'h0000_1234, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF, 12'h341, 32'h8000_0040, 32'h8000_0100};
        vecs[6]  = {32'h8000_0100, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0,         12'h342, 32'd11,        32'h8000_0104};
        vecs[7]  = {32'h8000_0104, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 5'd0,  32'h0,         12'h341, 32'h8000_0040, 32'h8000_0040};
        vecs[8]  = {32'h8000_0040, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 12'h123, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  32'h0,         12'h123, 32'h0,         32'h8000_0044};
        vecs[9]  = {32'h8000_0044, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 12'h300, 32'h0000_A5A5, 1'b0, 1'b0, 5'd0,  32'h0,         12'h300, 32'h0000_A5A5, 32'h8000_0048};
        vecs[10] = {32'h8000_0048, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 5'd0,  32'h0,         12'h341, 32'h8000_0048, 32'h8000_0100};

        clear_inputs();
        rst = 1'b1; IFU_ready = 1'b1;
        raddr1 = 5'd0; raddr2 = 5'd0; csr_raddr = 12'h300;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_pc", pc, 32'h3000_0000);
        check("reset_ready", {31'd0, WBU_ready}, 32'd1);
        check("reset_valid", {31'd0, WBU_valid}, 32'd0);
        check("reset_mstatus", csrrdata, 32'h0000_1800);

        for (int i = 0; i < 11; i++) begin
            clear_inputs();
            EXU_valid = 1'b1; exu_pc = vecs[i].pc; exu_imm = vecs[i].imm;
            exu_src1 = vecs[i].src1; PCAsrc = vecs[i].pca; PCBsrc = vecs[i].pcb;
            wd = vecs[i].wd; rd = vecs[i].rd; regwr = vecs[i].regwr;
            csrw = vecs[i].csrw; csr_addr = vecs[i].csr_addr; csrwdata = vecs[i].csrwdata;
            ecall = vecs[i].ecall; mret = vecs[i].mret;
            raddr1 = vecs[i].chk_raddr; raddr2 = vecs[i].chk_raddr; csr_raddr = vecs[i].chk_csr;
            IFU_ready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_valid", i), {31'd0, WBU_valid}, 32'd1);
            check($sformatf("v%0d_ready", i), {31'd0, WBU_ready}, 32'd0);
            check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp_rdata);
            check($sformatf("v%0d_rdata2", i), rdata2, vecs[i].exp_rdata);
            check($sformatf("v%0d_csr", i), csrrdata, vecs[i].exp_csr);
            clear_inputs();
            @(negedge clk);
            check($sformatf("v%0d_valid_drop", i), {31'd0, WBU_valid}, 32'd0);
            check($sformatf("v%0d_ready_back", i), {31'd0, WBU_ready}, 32'd1);
            check($sformatf("v%0d_pc_hold", i), pc, vecs[i].exp_pc);
        end

        // Back-pressure: offer held while execute presents a new instruction
        drive_plain(32'h8000_0100, 5'd7, 32'h0000_0077);
        IFU_ready = 1'b0; raddr1 = 5'd7; raddr2 = 5'd5;
        @(negedge clk);
        check("bp_commit_pc", pc, 32'h8000_0104);
        drive_plain(32'h0000_0200, 5'd7, 32'h0000_0BAD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", c), {31'd0, WBU_valid}, 32'd1);
            check($sformatf("bp%0d_ready", c), {31'd0, WBU_ready}, 32'd0);
            check($sformatf("bp%0d_pc", c), pc, 32'h8000_0104);
            check($sformatf("bp%0d_x7", c), rdata1, 32'h0000_0077);
        end
        IFU_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, WBU_ready}, 32'd1);
        check("bp_release_valid", {31'd0, WBU_valid}, 32'd0);
        check("bp_release_pc", pc, 32'h8000_0104);
        check("bp_release_x7", rdata1, 32'h0000_0077);
        @(negedge clk);
        check("bp_next_pc", pc, 32'h0000_0204);
        check("bp_next_x7", rdata1, 32'h0000_0BAD);
        check("bp_next_valid", {31'd0, WBU_valid}, 32'd1);
        clear_inputs();
        @(negedge clk);
        check("bp_done_ready", {31'd0, WBU_ready}, 32'd1);

        // Reset wins over a simultaneous commit
        drive_plain(32'h0000_0400, 5'd5, 32'h5555_5555);
        csrw = 1'b1; csr_addr = 12'h305; csrwdata = 32'h0000_FFFF;
        raddr1 = 5'd5; csr_raddr = 12'h305; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; clear_inputs();
        check("rstpri_pc", pc, 32'h3000_0000);
        check("rstpri_x5", rdata1, 32'hDEAD_BEEF);
        check("rstpri_mtvec", csrrdata, 32'h0);
        check("rstpri_valid", {31'd0, WBU_valid}, 32'd0);
        check("rstpri_ready", {31'd0, WBU_ready}, 32'd1);

        // Reset while offering discards the pending next PC
        drive_plain(32'h3000_0000, 5'd9, 32'h0000_0099);
        IFU_ready = 1'b0; csr_raddr = 12'h300;
        @(negedge clk);
        check("rstoffer_valid_pre", {31'd0, WBU_valid}, 32'd1);
        check("rstoffer_pc_pre", pc, 32'h3000_0004);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstoffer_valid", {31'd0, WBU_valid}, 32'd0);
        check("rstoffer_ready", {31'd0, WBU_ready}, 32'd1);
        check("rstoffer_pc", pc, 32'h3000_0000);
        check("rstoffer_mstatus", csrrdata, 32'h0000_1800);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
